// File: rtl/spi_pkg.sv
//==============================================================================
// Module   : spi_pkg
// Brief    : Shared types and constants for the SPI memory-link initiator.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

package spi_pkg;

    localparam int ADDR_W     = 7;
    localparam int DATA_W     = 8;
    localparam int FRAME_BITS = 16;

    localparam logic RW_READ = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_HOLD  = 3'd3,
        ST_GUARD = 3'd4
    } spi_state_t;

    // Frame layout on the wire, MSB first: address, rw flag, data (zero on reads).
    function automatic logic [FRAME_BITS-1:0] build_frame(
        input logic              rw,
        input logic [ADDR_W-1:0] addr,
        input logic [DATA_W-1:0] wdata
    );
        return {addr, rw, (rw == RW_READ) ? {DATA_W{1'b0}} : wdata};
    endfunction

endpackage

`default_nettype wire

// File: rtl/spi_sclk_gen.sv
//==============================================================================
// Module   : spi_sclk_gen
// Brief    : SCLK half-period counter emitting rise/fall/phase_end strobes.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module spi_sclk_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic rise,
    output logic fall,
    output logic phase_end
);

    localparam int               c_cnt_w = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(CLK_DIV - 1);
    localparam logic [c_cnt_w-1:0] c_one  = c_cnt_w'(1);

    logic [c_cnt_w-1:0] r_cnt;
    logic               r_level;

    // r_level tracks the phase being timed: a low phase ends in a rise, a high phase in a fall.
    assign phase_end = en && (r_cnt == c_last);
    assign rise      = phase_end && !r_level;
    assign fall      = phase_end &&  r_level;

    always_ff @(posedge clk) begin
        if (reset || !en) begin
            r_cnt   <= '0;
            r_level <= 1'b0;
        end else if (phase_end) begin
            r_cnt   <= '0;
            r_level <= ~r_level;
        end else begin
            r_cnt   <= r_cnt + c_one;
        end
    end

endmodule

`default_nettype wire

// File: rtl/spi_master.sv
//==============================================================================
// Module   : spi_master
// Brief    : SPI initiator framing single-cycle host requests for spiMemory.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module spi_master
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              rw,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rdata,
    output logic              sclk_pin,
    output logic              cs_pin,
    output logic              mosi_pin,
    input  logic              miso_pin
);

    localparam logic [3:0] c_last_bit  = 4'(FRAME_BITS - 1);
    localparam logic [3:0] c_first_dat = 4'(ADDR_W + 1);

    spi_state_t              r_state;
    logic [FRAME_BITS-1:0]   r_tx;
    logic [DATA_W-1:0]       r_rx;
    logic [DATA_W-1:0]       r_rdata;
    logic [3:0]              r_bit_cnt;
    logic                    r_rw;
    logic                    r_sclk;
    logic                    r_cs;
    logic                    r_done;

    logic w_en;
    logic w_rise;
    logic w_fall;
    logic w_phase_end;

    assign w_en = (r_state != ST_IDLE);

    spi_sclk_gen #(
        .CLK_DIV   (CLK_DIV)
    ) u_sclk_gen (
        .clk       (clk),
        .reset     (reset),
        .en        (w_en),
        .rise      (w_rise),
        .fall      (w_fall),
        .phase_end (w_phase_end)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_tx      <= '0;
            r_rx      <= '0;
            r_rdata   <= '0;
            r_bit_cnt <= '0;
            r_rw      <= 1'b0;
            r_sclk    <= 1'b0;
            r_cs      <= 1'b1;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state   <= ST_SETUP;
                        r_rw      <= rw;
                        r_tx      <= build_frame(rw, addr, wdata);
                        r_bit_cnt <= '0;
                        r_cs      <= 1'b0;
                    end
                end
                ST_SETUP: begin
                    if (w_rise) begin
                        r_state <= ST_SHIFT;
                        r_sclk  <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    // The tx register shifts in zeros, so mosi settles low once the frame is out.
                    if (w_fall) begin
                        r_sclk <= 1'b0;
                        r_tx   <= {r_tx[FRAME_BITS-2:0], 1'b0};
                        if (r_rw == RW_READ && r_bit_cnt >= c_first_dat) begin
                            r_rx <= {r_rx[DATA_W-2:0], miso_pin};
                        end
                    end else if (w_rise) begin
                        if (r_bit_cnt == c_last_bit) begin
                            r_state   <= ST_HOLD;
                            r_bit_cnt <= '0;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                            r_sclk    <= 1'b1;
                        end
                    end
                end
                ST_HOLD: begin
                    if (w_phase_end) begin
                        r_state <= ST_GUARD;
                        r_cs    <= 1'b1;
                        r_done  <= 1'b1;
                        if (r_rw == RW_READ) begin
                            r_rdata <= r_rx;
                        end
                    end
                end
                ST_GUARD: begin
                    if (w_phase_end) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy     = w_en;
    assign done     = r_done;
    assign rdata    = r_rdata;
    assign sclk_pin = r_sclk;
    assign cs_pin   = r_cs;
    assign mosi_pin = r_tx[FRAME_BITS-1];

endmodule

`default_nettype wire

// File: tb/tb_spi_master.sv
//==============================================================================
// Module   : tb_spi_master
// Brief    : Self-checking bench for spi_master with a behavioural spiMemory responder.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_spi_master;

    logic       clk = 1'b0;
    logic       reset = 1'b1;

    logic       start0 = 1'b0, rw0 = 1'b0;
    logic [6:0] addr0 = '0;
    logic [7:0] wdata0 = '0;
    logic       busy0, done0, sclk0, cs0, mosi0, miso0;
    logic [7:0] rdata0;

    logic       start1 = 1'b0, rw1 = 1'b0;
    logic [6:0] addr1 = '0;
    logic [7:0] wdata1 = '0;
    logic       busy1, done1, sclk1, cs1, mosi1;
    logic [7:0] rdata1;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    spi_master #(.CLK_DIV(4)) dut0 (
        .clk(clk), .reset(reset), .start(start0), .rw(rw0), .addr(addr0), .wdata(wdata0),
        .busy(busy0), .done(done0), .rdata(rdata0), .sclk_pin(sclk0), .cs_pin(cs0),
        .mosi_pin(mosi0), .miso_pin(miso0)
    );

    spi_master #(.CLK_DIV(7)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .rw(rw1), .addr(addr1), .wdata(wdata1),
        .busy(busy1), .done(done1), .rdata(rdata1), .sclk_pin(sclk1), .cs_pin(cs1),
        .mosi_pin(mosi1), .miso_pin(1'b0)
    );

    // Responder model for dut0: decodes the frame on SCLK rises, drives read data after falls.
    logic [7:0]  mem [128];
    logic        mem_init = 1'b0;
    logic        sclk0_q = 1'b0;
    int          rcnt = 0;
    logic [15:0] sh = '0;
    logic [15:0] last_frame = '0;
    logic [6:0]  m_addr = '0;
    logic        m_rd = 1'b0;
    int          cs_run = 0;
    int          cs_len = 0;
    int          done_cnt = 0;
    logic [7:0]  m_byte;

    initial miso0 = 1'b0;

    always @(negedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 128; i++) mem[i] = 8'h00;
            mem_init = 1'b1;
        end
        if (done0) done_cnt++;
        if (!cs0) begin
            cs_run++;
        end else begin
            if (cs_run != 0) cs_len = cs_run;
            cs_run = 0;
            rcnt   = 0;
            miso0  = 1'b0;
        end
        if (!cs0 && sclk0 && !sclk0_q) begin
            sh = {sh[14:0], mosi0};
            rcnt++;
            if (rcnt == 8) begin
                m_addr = sh[7:1];
                m_rd   = sh[0];
            end
            if (rcnt == 16) begin
                last_frame = sh;
                if (!m_rd) mem[m_addr] = sh[7:0];
            end
        end
        if (!cs0 && !sclk0 && sclk0_q && m_rd && rcnt >= 8 && rcnt <= 15) begin
            m_byte = mem[m_addr];
            miso0  = m_byte[3'(15 - rcnt)];
        end
        sclk0_q = sclk0;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // One dut0 transaction; host inputs are scrambled after acceptance to prove they were latched.
    task automatic txn0(input logic t_rw, input logic [6:0] t_addr, input logic [7:0] t_wdata,
                        input logic [7:0] rd_before, output int lat, output int ndone);
        int base;
        int n;
        base = done_cnt;
        @(negedge clk);
        start0 = 1'b1; rw0 = t_rw; addr0 = t_addr; wdata0 = t_wdata;
        @(negedge clk);
        start0 = 1'b0; rw0 = ~t_rw; addr0 = ~t_addr; wdata0 = ~t_wdata;
        n = 1;
        chk("busy_cs_first_cycle", {30'd0, busy0, cs0}, 32'd2);
        lat = -1;
        while (n < 400) begin
            if (n == 100) chk("rdata_before_done", {24'd0, rdata0}, {24'd0, rd_before});
            if (done0) begin
                lat = n;
                break;
            end
            @(negedge clk);
            n++;
        end
        n = 0;
        while (busy0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        ndone = done_cnt - base;
    endtask

    typedef struct {
        logic        rw;
        logic [6:0]  addr;
        logic [7:0]  wdata;
        logic [15:0] frame;
        logic [7:0]  rdata;
    } vec_t;

    vec_t vecs[8];

    initial begin : main
        int lat, nd, n, base;
        logic [7:0] exp_rd;
        int r1, f1, r2, l1;
        logic prev;

        vecs[0] = '{1'b0, 7'h61, 8'hB1, 16'hC2B1, 8'h00};
        vecs[1] = '{1'b1, 7'h61, 8'h00, 16'hC300, 8'hB1};
        vecs[2] = '{1'b0, 7'h12, 8'h5A, 16'h245A, 8'hB1};
        vecs[3] = '{1'b1, 7'h12, 8'hFF, 16'h2500, 8'h5A};
        vecs[4] = '{1'b0, 7'h7F, 8'hFF, 16'hFEFF, 8'h5A};
        vecs[5] = '{1'b1, 7'h7F, 8'h00, 16'hFF00, 8'hFF};
        vecs[6] = '{1'b0, 7'h00, 8'h00, 16'h0000, 8'hFF};
        vecs[7] = '{1'b1, 7'h00, 8'hAA, 16'h0100, 8'h00};

        repeat (3) @(negedge clk);
        start0 = 1'b1;
        @(negedge clk);
        chk("reset_cs", {31'd0, cs0}, 32'd1);
        chk("reset_sclk_mosi_busy_done", {28'd0, sclk0, mosi0, busy0, done0}, 32'd0);
        chk("reset_rdata", {24'd0, rdata0}, 32'd0);
        start0 = 1'b0;
        reset  = 1'b0;

        exp_rd = 8'h00;
        for (int i = 0; i < 8; i++) begin
            txn0(vecs[i].rw, vecs[i].addr, vecs[i].wdata, exp_rd, lat, nd);
            chk($sformatf("v%0d_frame", i), {16'd0, last_frame}, {16'd0, vecs[i].frame});
            chk($sformatf("v%0d_cs_low", i), cs_len, 136);
            chk($sformatf("v%0d_done_count", i), nd, 1);
            chk($sformatf("v%0d_done_latency", i), lat, 137);
            chk($sformatf("v%0d_rdata", i), {24'd0, rdata0}, {24'd0, vecs[i].rdata});
            exp_rd = vecs[i].rdata;
        end

        // Back-to-back: write 3C then read it back, start issued in the cycle busy falls.
        base = done_cnt;
        @(negedge clk);
        start0 = 1'b1; rw0 = 1'b0; addr0 = 7'h33; wdata0 = 8'h3C;
        @(negedge clk);
        start0 = 1'b0;
        n = 1;
        while (busy0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("b2b_busy_fall", n, 141);
        start0 = 1'b1; rw0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        chk("b2b_second_accept", {30'd0, busy0, cs0}, 32'd2);
        n = 1;
        while (!done0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("b2b_latency", n, 137);
        chk("b2b_rdata", {24'd0, rdata0}, 32'h3C);
        while (busy0 && n < 800) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        chk("b2b_done_count", done_cnt - base, 2);
        chk("b2b_frame", {16'd0, last_frame}, 32'h6700);

        // Start pulsed during SCLK period 5 must be ignored.
        base = done_cnt;
        @(negedge clk);
        start0 = 1'b1; rw0 = 1'b0; addr0 = 7'h44; wdata0 = 8'h99;
        @(negedge clk);
        start0 = 1'b0;
        n = 1;
        while (n < 46) begin
            @(negedge clk);
            n++;
        end
        start0 = 1'b1; rw0 = 1'b1; addr0 = 7'h11; wdata0 = 8'h00;
        @(negedge clk);
        start0 = 1'b0;
        n = 0;
        while (n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("ignored_start_idle", {31'd0, busy0}, 32'd0);
        chk("ignored_start_done_count", done_cnt - base, 1);
        chk("ignored_start_frame", {16'd0, last_frame}, 32'h8899);

        // Reset during data bit 10 of a read.
        base = done_cnt;
        @(negedge clk);
        start0 = 1'b1; rw0 = 1'b1; addr0 = 7'h61; wdata0 = 8'h00;
        @(negedge clk);
        start0 = 1'b0;
        n = 1;
        while (n < 86) begin
            @(negedge clk);
            n++;
        end
        chk("pre_reset_sclk_high", {31'd0, sclk0}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_cs", {31'd0, cs0}, 32'd1);
        chk("abort_sclk_busy_mosi", {29'd0, sclk0, busy0, mosi0}, 32'd0);
        chk("abort_rdata", {24'd0, rdata0}, 32'd0);
        reset = 1'b0;
        repeat (200) @(negedge clk);
        chk("abort_no_done", done_cnt - base, 0);

        // CLK_DIV = 7 timing.
        @(negedge clk);
        start1 = 1'b1; rw1 = 1'b0; addr1 = 7'h2A; wdata1 = 8'h5C;
        @(negedge clk);
        start1 = 1'b0;
        n = 1;
        chk("div7_first_cycle", {30'd0, busy1, cs1}, 32'd2);
        r1 = -1; f1 = -1; r2 = -1; l1 = -1; prev = 1'b0;
        while (n < 600 && l1 < 0) begin
            if (sclk1 && !prev) begin
                if (r1 < 0) r1 = n;
                else if (r2 < 0) r2 = n;
            end
            if (!sclk1 && prev && f1 < 0) f1 = n;
            if (done1) l1 = n;
            prev = sclk1;
            @(negedge clk);
            n++;
        end
        chk("div7_first_rise", r1, 8);
        chk("div7_high_phase", f1 - r1, 7);
        chk("div7_low_phase", r2 - f1, 7);
        chk("div7_done_latency", l1, 239);
        while (busy1 && n < 600) begin
            @(negedge clk);
            n++;
        end
        chk("div7_busy_fall", n, 246);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
